// File: rtl/button_event_if.sv
// Button front-end bundle: raw button pins in, event pulses and levels out.
// master = board/driver side, slave = conditioner side.
interface button_event_if;
  logic       btn_inc_raw;
  logic       btn_set_raw;
  logic       btn_sw_raw;
  logic       inc_short;
  logic       inc_long;
  logic       set;
  logic       sw;
  logic [2:0] btn_level;

  modport master (
    output btn_inc_raw, btn_set_raw, btn_sw_raw,
    input  inc_short, inc_long, set, sw, btn_level
  );

  modport slave (
    input  btn_inc_raw, btn_set_raw, btn_sw_raw,
    output inc_short, inc_long, set, sw, btn_level
  );
endinterface

// File: rtl/button_event_conditioner.sv
// Sync, debounce and classify INC/SET/SW buttons into one-hot event pulses.
// Define BTN_ACTIVE_LOW_EN for buttons that pull low when pressed.
module button_event_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int CNT_W           = 26
) (
  input  logic           clk,
  input  logic           rst,
  button_event_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } inc_st_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LG_LAST = CNT_W'(LONG_CYCLES - 1);

  // bit order everywhere: {sw, set, inc}
  logic [2:0] raw;
`ifdef BTN_ACTIVE_LOW_EN
  assign raw = ~{bus.btn_sw_raw, bus.btn_set_raw, bus.btn_inc_raw};
`else
  assign raw = {bus.btn_sw_raw, bus.btn_set_raw, bus.btn_inc_raw};
`endif

  logic [2:0]       s1_q, s2_q;
  logic [2:0]       db_q, db_d;
  logic [2:0]       dbp_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       rise;

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) db_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise = db_q & ~dbp_q;

  inc_st_e          st_q, st_d;
  logic [CNT_W-1:0] hc_q, hc_d;
  logic             ev_short, ev_long;

  always_comb begin
    st_d     = st_q;
    hc_d     = hc_q;
    ev_short = 1'b0;
    ev_long  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (rise[0]) begin
          st_d = PRESSED;
          hc_d = '0;
        end
      end
      PRESSED: begin
        // a release in the threshold cycle still counts as short
        if (!db_q[0]) begin
          ev_short = 1'b1;
          st_d     = IDLE;
        end else if (hc_q == LG_LAST) begin
          ev_long = 1'b1;
          st_d    = LONG;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      LONG: begin
        if (!db_q[0]) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // {set, sw, long, short}, highest bit wins
  logic [3:0] pend_q, pend_d;
  logic [3:0] out_q, out_d;
  logic [3:0] req;

  always_comb begin
    req   = pend_q | {rise[1], rise[2], ev_long, ev_short};
    out_d = '0;
    if (req[3])      out_d[3] = 1'b1;
    else if (req[2]) out_d[2] = 1'b1;
    else if (req[1]) out_d[1] = 1'b1;
    else if (req[0]) out_d[0] = 1'b1;
    pend_d = req & ~out_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      dbp_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      st_q   <= IDLE;
      hc_q   <= '0;
      pend_q <= '0;
      out_q  <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      db_q   <= db_d;
      dbp_q  <= db_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      st_q   <= st_d;
      hc_q   <= hc_d;
      pend_q <= pend_d;
      out_q  <= out_d;
    end
  end

  assign bus.set       = out_q[3];
  assign bus.sw        = out_q[2];
  assign bus.inc_long  = out_q[1];
  assign bus.inc_short = out_q[0];
  assign bus.btn_level = db_q;

endmodule

// File: tb/tb_button_event_conditioner.sv
// Random + directed bench for button_event_conditioner (D=4, L=16).
// Reference model works on sample windows and press timestamps.
module tb_button_event_conditioner;
  localparam int D = 4;
  localparam int L = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  button_event_if bus ();

  button_event_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .CNT_W          (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // reference model state; pressed levels {sw,set,inc}
  bit [2:0] m_s1, m_s2, m_db;
  bit       m_hist [3][$];
  int       m_t;
  int       m_start;
  bit       m_inpress, m_longdone;
  bit [3:0] m_pend, m_out;

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    for (int b = 0; b < 3; b++) m_hist[b].delete();
    m_inpress = 1'b0; m_longdone = 1'b0;
    m_pend = '0; m_out = '0;
  endtask

  // model of one rising clock edge given the pressed levels sampled there
  task automatic m_edge(input bit [2:0] pr, input bit r);
    bit [2:0] ndb, rs, fl;
    bit [3:0] ev;
    if (r) begin
      m_reset();
      return;
    end
    m_t++;
    m_out = '0;
    for (int k = 3; k >= 0; k--)
      if (m_pend[k] && m_out == '0) m_out[k] = 1'b1;
    m_pend &= ~m_out;
    // level accepted once the last D synchronized samples all disagree
    ndb = m_db;
    for (int b = 0; b < 3; b++) begin
      if (m_hist[b].size() >= D) begin
        bit all_diff = 1'b1;
        for (int k = 0; k < D; k++)
          if (m_hist[b][m_hist[b].size()-1-k] == m_db[b]) all_diff = 1'b0;
        if (all_diff) ndb[b] = ~m_db[b];
      end
    end
    rs = ndb & ~m_db;
    fl = ~ndb & m_db;
    m_db = ndb;
    ev = '0;
    ev[3] = rs[1];
    ev[2] = rs[2];
    if (rs[0]) begin
      m_inpress = 1'b1; m_longdone = 1'b0; m_start = m_t;
    end else if (m_inpress) begin
      if (fl[0]) begin
        if (!m_longdone) ev[0] = 1'b1;
        m_inpress = 1'b0;
      end else if (!m_longdone && (m_t - m_start) == L) begin
        ev[1] = 1'b1;
        m_longdone = 1'b1;
      end
    end
    m_pend |= ev;
    m_s2 = m_s1;
    m_s1 = pr;
    for (int b = 0; b < 3; b++) begin
      m_hist[b].push_back(m_s2[b]);
      if (m_hist[b].size() > D) void'(m_hist[b].pop_front());
    end
  endtask

  function automatic logic [3:0] dut_ev();
    return {bus.set, bus.sw, bus.inc_long, bus.inc_short};
  endfunction

  // drive pins, step model over the next posedge, compare at the negedge
  task automatic cyc(input bit [2:0] pr, input bit r);
    rst = r;
`ifdef BTN_ACTIVE_LOW_EN
    {bus.btn_sw_raw, bus.btn_set_raw, bus.btn_inc_raw} = ~pr;
`else
    {bus.btn_sw_raw, bus.btn_set_raw, bus.btn_inc_raw} = pr;
`endif
    m_edge(pr, r);
    @(negedge clk);
    chk("events", dut_ev(), m_out);
    chk("level", bus.btn_level, m_db);
    chk("onehot", $onehot0(dut_ev()), 1);
  endtask

  int cnt [3];
  bit [2:0] lv;

  initial begin
    m_t = 0;
    m_start = 0;
    m_reset();
    cyc(3'b000, 1'b1);
    cyc(3'b000, 1'b1);
    chk("reset_ev", dut_ev(), 4'h0);
    chk("reset_lvl", bus.btn_level, 3'b000);
    repeat (3) cyc(3'b000, 1'b0);

    // SET press: pulse exactly at E6
    cyc(3'b010, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      cyc(3'b010, 1'b0);
      chk("set_e6", bus.set, (k == 6));
      chk("set_only", {bus.sw, bus.inc_long, bus.inc_short}, 3'b000);
    end
    repeat (12) cyc(3'b000, 1'b0);

    // INC glitch shorter than debounce
    repeat (3) cyc(3'b001, 1'b0);
    repeat (10) begin
      cyc(3'b000, 1'b0);
      chk("glitch_lvl", bus.btn_level[0], 1'b0);
      chk("glitch_ev", dut_ev(), 4'h0);
    end

    // SET and SW together: set at E6, sw at E7
    cyc(3'b110, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      cyc(3'b110, 1'b0);
      chk("pair_set", bus.set, (k == 6));
      chk("pair_sw", bus.sw, (k == 7));
    end
    repeat (12) cyc(3'b000, 1'b0);

    // INC held long: one long pulse, no short on release
    repeat (40) cyc(3'b001, 1'b0);
    repeat (12) cyc(3'b000, 1'b0);

    // reset in the middle of a press discards everything
    repeat (D + 2 + 10) cyc(3'b001, 1'b0);
    cyc(3'b000, 1'b1);
    cyc(3'b000, 1'b1);
    repeat (30) begin
      cyc(3'b000, 1'b0);
      chk("rst_mid_ev", dut_ev(), 4'h0);
    end

    // random segments with bounces, long holds and occasional resets
    lv = '0;
    for (int b = 0; b < 3; b++) cnt[b] = $urandom_range(1, 20);
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 3; b++) begin
        cnt[b]--;
        if (cnt[b] <= 0) begin
          lv[b] = ~lv[b];
          case ($urandom_range(0, 3))
            0: cnt[b] = $urandom_range(1, D);
            1: cnt[b] = $urandom_range(D, D + 3);
            2: cnt[b] = $urandom_range(D + L - 3, D + L + 4);
            default: cnt[b] = $urandom_range(1, 40);
          endcase
        end
      end
      cyc(lv, ($urandom_range(0, 599) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
